// File: rtl/gan_pkg.sv
// Shared types for the discriminator front end: arbiter FSM encoding and a width helper.
package gan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DELIVER,
    ST_ABORT
  } arb_state_t;

  // ceil(log2(v)), never less than 1 so single-entry indices still get a bit
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import gan_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_sampler_arbiter.sv
// Time-shares one frame_sampler between NUM_REQ producers: round-robin grant, frame mux,
// start/wait/deliver sequencing with a watchdog, and a valid/ready result register.
module frame_sampler_arbiter
  import gan_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int INPUT_COUNT    = 784,
  parameter  int OUTPUT_COUNT   = 256,
  parameter  int DATA_WIDTH     = 16,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW             = clog2_min1(NUM_REQ),
  localparam int FW             = DATA_WIDTH * INPUT_COUNT,
  localparam int OW             = DATA_WIDTH * OUTPUT_COUNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*FW-1:0] req_frame_flat,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  smp_rst,
  output logic                  smp_start,
  output logic [FW-1:0]         smp_frame_flat,
  input  logic                  smp_busy,
  input  logic                  smp_done,
  input  logic [OW-1:0]         smp_sampled_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_sampled_flat,
  output logic [IW-1:0]         out_src_id,
  output logic                  timeout_err
);

  localparam int WW = clog2_min1(TIMEOUT_CYCLES);

  arb_state_t           state;
  logic [IW-1:0]        ptr, owner, arb_idx, ptr_nxt;
  logic [NUM_REQ-1:0]   req_m, arb_gnt;
  logic [WW-1:0]        wdog;

  // A producer whose done pulse is in flight must not be re-granted on the same edge
  assign req_m = req & ~req_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_m),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) arb_idx = IW'(i);
  end

  assign ptr_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    smp_frame_flat = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) smp_frame_flat = smp_frame_flat | req_frame_flat[i*FW +: FW];
  end

  assign smp_rst = ~rst_n | (state == ST_ABORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      grant            <= '0;
      owner            <= '0;
      ptr              <= '0;
      req_done         <= '0;
      smp_start        <= 1'b0;
      wdog             <= '0;
      out_valid        <= 1'b0;
      out_sampled_flat <= '0;
      out_src_id       <= '0;
      timeout_err      <= 1'b0;
    end else begin
      req_done    <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|arb_gnt) begin
            grant     <= arb_gnt;
            owner     <= arb_idx;
            smp_start <= ~smp_busy;
            state     <= ST_START;
          end
        end
        ST_START: begin
          // start stays low while the sampler reports busy; once it fires we leave
          if (smp_start) begin
            smp_start <= 1'b0;
            wdog      <= '0;
            state     <= ST_WAIT;
          end else begin
            smp_start <= ~smp_busy;
          end
        end
        ST_WAIT: begin
          if (smp_done) begin
            out_sampled_flat <= smp_sampled_flat;
            out_src_id       <= owner;
            out_valid        <= 1'b1;
            state            <= ST_DELIVER;
          end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            req_done    <= grant;
            state       <= ST_ABORT;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_DELIVER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_done  <= grant;
            grant     <= '0;
            ptr       <= ptr_nxt;
            state     <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          grant <= '0;
          ptr   <= ptr_nxt;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sampler_arbiter.sv
// Directed bench for frame_sampler_arbiter with a behavioural sampler stub.
module tb_frame_sampler_arbiter;

  localparam int NR = 3;
  localparam int IC = 48;
  localparam int OC = 16;
  localparam int DW = 16;
  localparam int TO = 300;
  localparam int FW = DW * IC;
  localparam int OW = DW * OC;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*FW-1:0] req_frame_flat;
  logic [NR-1:0]    grant, req_done;
  logic             smp_rst, smp_start, smp_busy, smp_done;
  logic [FW-1:0]    smp_frame_flat;
  logic [OW-1:0]    smp_sampled_flat;
  logic             out_valid, out_ready, timeout_err;
  logic [OW-1:0]    out_sampled_flat;
  logic [1:0]       out_src_id;

  frame_sampler_arbiter #(
    .NUM_REQ(NR), .INPUT_COUNT(IC), .OUTPUT_COUNT(OC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_frame_flat(req_frame_flat),
    .grant(grant), .req_done(req_done), .smp_rst(smp_rst), .smp_start(smp_start),
    .smp_frame_flat(smp_frame_flat), .smp_busy(smp_busy), .smp_done(smp_done),
    .smp_sampled_flat(smp_sampled_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_sampled_flat(out_sampled_flat), .out_src_id(out_src_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // sampler stub: OC+1 cycles after start, result[k] = frame[k*IC/OC]
  bit            stub_hang = 1'b0, force_busy = 1'b0, stray_done = 1'b0;
  logic          running = 1'b0, stub_done = 1'b0;
  int            cnt = 0;
  logic [FW-1:0] latched = '0;
  logic [OW-1:0] sampled = '0;

  assign smp_busy         = running | force_busy;
  assign smp_done         = stub_done | stray_done;
  assign smp_sampled_flat = sampled;

  function automatic logic [OW-1:0] downsample(input logic [FW-1:0] f);
    logic [OW-1:0] r;
    for (int k = 0; k < OC; k++) r[k*DW +: DW] = f[((k*IC)/OC)*DW +: DW];
    return r;
  endfunction

  always @(posedge clk) begin
    if (smp_rst) begin
      running   <= 1'b0;
      stub_done <= 1'b0;
      cnt       <= 0;
    end else begin
      stub_done <= 1'b0;
      if (running) begin
        if (!stub_hang && cnt == OC) begin
          stub_done <= 1'b1;
          running   <= 1'b0;
          sampled   <= downsample(latched);
        end else cnt <= cnt + 1;
      end else if (smp_start) begin
        running <= 1'b1;
        cnt     <= 0;
        latched <= smp_frame_flat;
      end
    end
  end

  // monitor, sampled 1 time unit after each rising edge
  int            cyc = 0, start_cnt = 0, done_cnt = 0, start_cyc = 0, to_cyc = 0;
  bit            onehot_bad = 1'b0;
  int            gorder[$];

  function automatic int idx_of(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (smp_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      gorder.push_back(idx_of(grant));
    end
    if ($countones(grant) > 1) onehot_bad = 1'b1;
    if (|req_done) done_cnt++;
    if (timeout_err === 1'b1) to_cyc = cyc;
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_frames(input int salt);
    for (int p = 0; p < NR; p++)
      for (int i = 0; i < IC; i++)
        req_frame_flat[(p*IC+i)*DW +: DW] = DW'(p*100 + i + salt);
  endtask

  // hand-derived: IC/OC = 3, so result sample k comes from input sample 3k
  function automatic logic [OW-1:0] exp_res(input int p, input int salt);
    logic [OW-1:0] r;
    for (int k = 0; k < OC; k++) r[k*DW +: DW] = DW'(p*100 + 3*k + salt);
    return r;
  endfunction

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_done(input string tag, input int target, input int max);
    int n;
    n = 0;
    while (done_cnt < target && n < max) begin @(negedge clk); n++; end
    chk(tag, done_cnt, target);
  endtask

  logic [OW-1:0] snap;
  logic [1:0]    sid;
  int            s0, base, n;
  bit            stable;

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b1;
    req_frame_flat = '0;
    set_frames(0);
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_smp_rst", smp_rst, 1);
    chk("rst_start", smp_start, 0);
    chk("rst_src_id", out_src_id, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_done", req_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_smp_rst", smp_rst, 0);

    // stray done while idle must not produce a result
    stray_done = 1'b1; @(negedge clk); stray_done = 1'b0; @(negedge clk);
    chk("stray_done_ignored", out_valid, 0);

    // T1: single requester 0
    set_frames(7); req = 3'b001;
    @(negedge clk);
    chk("t1_grant", grant, 3'b001);
    chk("t1_start", smp_start, 1);
    wait_valid("t1_valid", 100);
    chk("t1_data", out_sampled_flat, exp_res(0, 7));
    chk("t1_id", out_src_id, 0);
    @(negedge clk);
    chk("t1_req_done", req_done, 3'b001);
    chk("t1_grant_clr", grant, 0);
    chk("t1_valid_clr", out_valid, 0);
    chk("t1_starts", start_cnt, 1);
    req = '0;

    // T2: 0 and 1 held for 4 frames; pointer sits at 1 after T1
    gorder.delete(); base = done_cnt; set_frames(11); req = 3'b011;
    wait_done("t2_done_cnt", base + 4, 400);
    req = '0;
    chk("t2_nstarts", gorder.size(), 4);
    if (gorder.size() == 4) begin
      chk("t2_order0", gorder[0], 1);
      chk("t2_order1", gorder[1], 0);
      chk("t2_order2", gorder[2], 1);
      chk("t2_order3", gorder[3], 0);
    end

    // T3: backpressure on requester 2
    out_ready = 1'b0; set_frames(20); req = 3'b100;
    wait_valid("t3_valid", 100);
    snap = out_sampled_flat; sid = out_src_id; s0 = start_cnt; stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sampled_flat !== snap || out_src_id !== sid) stable = 1'b0;
    end
    chk("t3_stable", stable, 1);
    chk("t3_no_start", start_cnt, s0);
    chk("t3_data", snap, exp_res(2, 20));
    chk("t3_id", sid, 2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_req_done", req_done, 3'b100);
    chk("t3_valid_clr", out_valid, 0);
    req = '0;

    // T4: hung sampler on requester 0, then requester 1 served
    stub_hang = 1'b1; set_frames(40); req = 3'b011; gorder.delete();
    n = 0;
    while (timeout_err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk("t4_timeout_seen", timeout_err, 1);
    chk("t4_timeout_latency", to_cyc - start_cyc, TO + 1);
    chk("t4_smp_rst", smp_rst, 1);
    chk("t4_req_done", req_done, 3'b001);
    stub_hang = 1'b0; req = 3'b010;
    wait_valid("t4_valid", 100);
    chk("t4_next_id", out_src_id, 1);
    chk("t4_data", out_sampled_flat, exp_res(1, 40));
    chk("t4_nstarts", gorder.size(), 2);
    if (gorder.size() == 2) chk("t4_order1", gorder[1], 1);
    @(negedge clk);
    req = '0;

    // T5: reset while waiting on the sampler
    set_frames(60); req = 3'b001;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_grant_rst", grant, 0);
    chk("t5_valid_rst", out_valid, 0);
    chk("t5_smp_rst", smp_rst, 1);
    @(negedge clk);
    rst_n = 1'b1; gorder.delete();
    wait_valid("t5_valid", 100);
    chk("t5_id", out_src_id, 0);
    chk("t5_data", out_sampled_flat, exp_res(0, 60));
    chk("t5_nstarts", gorder.size(), 1);
    @(negedge clk);
    req = '0;

    // T6: sampler busy holds off start
    force_busy = 1'b1; set_frames(80); req = 3'b010; s0 = start_cnt;
    repeat (10) @(negedge clk);
    chk("t6_grant", grant, 3'b010);
    chk("t6_no_start", start_cnt, s0);
    force_busy = 1'b0;
    wait_valid("t6_valid", 100);
    chk("t6_one_start", start_cnt, s0 + 1);
    chk("t6_data", out_sampled_flat, exp_res(1, 80));
    chk("t6_id", out_src_id, 1);
    @(negedge clk);
    req = '0;
    chk("grant_onehot", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
